// File: rtl/sram_controller.sv
// Bus slave that sequences the off-chip 32-bit SRAM with fixed setup/pulse/hold timing.
module sram_controller #(
  parameter int unsigned READ_CYCLES  = 2,
  parameter int unsigned WRITE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] bus_address,
  input  logic        bus_read,
  input  logic        bus_write,
  input  logic [31:0] bus_data_wr,
  input  logic [3:0]  bus_mask,
  output logic        bus_stall,
  output logic [31:0] bus_data_rd,
  output logic [19:0] sram_address,
  output logic [31:0] sram_data_o,
  output logic        sram_data_oe,
  input  logic [31:0] sram_data_i,
  output logic [3:0]  sram_be_n,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_CYCLES - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] count;

  // Address bits outside the 4 MB word window are ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus_address[31:22], bus_address[1:0]};

  // Stall any pending request until the controller reaches DONE.
  assign bus_stall = (bus_read | bus_write) & (state != DONE);

  // Sequencer: pin levels are registered together with the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      count        <= '0;
      bus_data_rd  <= '0;
      sram_address <= '0;
      sram_data_o  <= '0;
      sram_data_oe <= 1'b0;
      sram_be_n    <= 4'hF;
      sram_ce_n    <= 1'b1;
      sram_oe_n    <= 1'b1;
      sram_we_n    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus_write) begin
            sram_address <= bus_address[21:2];
            sram_data_o  <= bus_data_wr;
            count        <= '0;
            if (bus_mask == 4'h0) begin
              // Nothing to write: acknowledge without touching the chip.
              state <= DONE;
            end else begin
              state        <= WR_SETUP;
              sram_ce_n    <= 1'b0;
              sram_oe_n    <= 1'b1;
              sram_we_n    <= 1'b1;
              sram_be_n    <= ~bus_mask;
              sram_data_oe <= 1'b1;
            end
          end else if (bus_read) begin
            state        <= RD;
            count        <= RD_LOAD;
            sram_address <= bus_address[21:2];
            sram_ce_n    <= 1'b0;
            sram_oe_n    <= 1'b0;
            sram_we_n    <= 1'b1;
            sram_be_n    <= 4'h0;
            sram_data_oe <= 1'b0;
          end
        end
        RD: begin
          if (count == '0) begin
            bus_data_rd <= sram_data_i;
            state       <= DONE;
            sram_ce_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
            sram_be_n   <= 4'hF;
          end else begin
            count <= count - 1'b1;
          end
        end
        WR_SETUP: begin
          state     <= WR_PULSE;
          count     <= WR_LOAD;
          sram_we_n <= 1'b0;
        end
        WR_PULSE: begin
          if (count == '0) begin
            state     <= WR_HOLD;
            sram_we_n <= 1'b1;
          end else begin
            count <= count - 1'b1;
          end
        end
        WR_HOLD: begin
          state        <= DONE;
          count        <= '0;
          sram_ce_n    <= 1'b1;
          sram_oe_n    <= 1'b1;
          sram_we_n    <= 1'b1;
          sram_be_n    <= 4'hF;
          sram_data_oe <= 1'b0;
        end
        DONE: begin
          state <= IDLE;
          count <= '0;
        end
        default: begin
          state        <= IDLE;
          count        <= '0;
          sram_ce_n    <= 1'b1;
          sram_oe_n    <= 1'b1;
          sram_we_n    <= 1'b1;
          sram_be_n    <= 4'hF;
          sram_data_oe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller: chip model, reference memory, random traffic.
module tb_sram_controller;

  localparam int unsigned RC = 2;
  localparam int unsigned WC = 2;

  logic        clk;
  logic        rst_n;
  logic [31:0] bus_address;
  logic        bus_read;
  logic        bus_write;
  logic [31:0] bus_data_wr;
  logic [3:0]  bus_mask;
  logic        bus_stall;
  logic [31:0] bus_data_rd;
  logic [19:0] sram_address;
  logic [31:0] sram_data_o;
  logic        sram_data_oe;
  logic [31:0] sram_data_i;
  logic [3:0]  sram_be_n;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;

  int total;
  int bad;

  sram_controller #(.READ_CYCLES(RC), .WRITE_CYCLES(WC)) dut (
    .clk(clk), .rst_n(rst_n),
    .bus_address(bus_address), .bus_read(bus_read), .bus_write(bus_write),
    .bus_data_wr(bus_data_wr), .bus_mask(bus_mask), .bus_stall(bus_stall),
    .bus_data_rd(bus_data_rd), .sram_address(sram_address), .sram_data_o(sram_data_o),
    .sram_data_oe(sram_data_oe), .sram_data_i(sram_data_i), .sram_be_n(sram_be_n),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Chip model: 1024 words, byte-writable while ce_n and we_n are low.
  logic [31:0] chip [0:1023];
  initial begin
    for (int i = 0; i < 1024; i++) chip[i] = 32'h0;
    forever begin
      @(posedge clk);
      if (!sram_ce_n && !sram_we_n && sram_data_oe) begin
        for (int b = 0; b < 4; b++)
          if (!sram_be_n[b]) chip[sram_address[9:0]][8*b +: 8] = sram_data_o[8*b +: 8];
      end
    end
  end
  assign sram_data_i = (!sram_ce_n && !sram_oe_n && !sram_data_oe) ? chip[sram_address[9:0]] : 32'hBAD0_BAD0;

  // Length of the most recent run of ce_n-high cycles between two chip cycles.
  int ce_gap;
  int last_gap;
  initial begin
    ce_gap = 0;
    last_gap = 0;
    forever begin
      @(negedge clk);
      if (!sram_ce_n) begin
        if (ce_gap > 0) last_gap = ce_gap;
        ce_gap = 0;
      end else begin
        ce_gap = ce_gap + 1;
      end
    end
  end

  // Reference model: word memory with byte merge, and the read data the bus should hold.
  logic [31:0] ref_mem [0:1023];
  logic [31:0] exp_rd;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data, input logic [3:0] mask);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (mask[b]) r[8*b +: 8] = data[8*b +: 8];
    return r;
  endfunction

  typedef struct packed {
    int          stalls;
    int          we_lo;
    int          oe_lo;
    int          doe;
    int          ce_lo;
    logic [19:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rd;
  } obs_t;

  // Present one request, hold it until stall drops, record pin activity along the way.
  task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] mask,
                         input bit scramble, output obs_t o);
    bit done;
    o = '0;
    done = 1'b0;
    @(negedge clk);
    bus_read = rd; bus_write = wr; bus_address = addr; bus_data_wr = data; bus_mask = mask;
    for (int cyc = 0; cyc < 40; cyc++) begin
      #1;
      if (!sram_ce_n) begin o.ce_lo++; o.addr = sram_address; end
      if (!sram_oe_n) o.oe_lo++;
      if (sram_data_oe) o.doe++;
      if (!sram_we_n) begin o.we_lo++; o.be = sram_be_n; o.wdata = sram_data_o; end
      if (!bus_stall) begin o.rd = bus_data_rd; done = 1'b1; break; end
      o.stalls++;
      @(negedge clk);
      if (scramble) begin
        bus_address = $urandom; bus_data_wr = $urandom; bus_mask = 4'($urandom);
      end
    end
    bus_read = 1'b0; bus_write = 1'b0;
    total++;
    if (!done) begin
      bad++;
      $display("FAIL txn_timeout: stall still high after 40 cycles, required low");
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus_read = 1'b0; bus_write = 1'b0; bus_address = '0; bus_data_wr = '0; bus_mask = '0;
    exp_rd = 32'h0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    total++; if (sram_ce_n !== 1'b1) begin bad++; $display("FAIL reset_ce_n: got %b want 1", sram_ce_n); end
    total++; if (sram_oe_n !== 1'b1) begin bad++; $display("FAIL reset_oe_n: got %b want 1", sram_oe_n); end
    total++; if (sram_we_n !== 1'b1) begin bad++; $display("FAIL reset_we_n: got %b want 1", sram_we_n); end
    total++; if (sram_be_n !== 4'hF) begin bad++; $display("FAIL reset_be_n: got %h want f", sram_be_n); end
    total++; if (sram_data_oe !== 1'b0) begin bad++; $display("FAIL reset_data_oe: got %b want 0", sram_data_oe); end
    total++; if (sram_address !== 20'h0) begin bad++; $display("FAIL reset_addr: got %h want 0", sram_address); end
    total++; if (bus_data_rd !== 32'h0) begin bad++; $display("FAIL reset_rd: got %h want 0", bus_data_rd); end
    total++; if (bus_stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", bus_stall); end
  endtask

  task automatic test_read();
    obs_t o;
    // Put 0xDEADBEEF into word 4 through the controller, then read it back.
    run_txn(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, o);
    ref_mem[4] = merge(ref_mem[4], 32'hDEAD_BEEF, 4'hF);
    run_txn(1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 1'b0, o);
    exp_rd = ref_mem[4];
    total++; if (o.addr !== 20'h4) begin bad++; $display("FAIL read_addr: got %h want 4", o.addr); end
    total++; if (o.oe_lo != int'(RC)) begin bad++; $display("FAIL read_oe_cycles: got %0d want %0d", o.oe_lo, RC); end
    total++; if (o.stalls != int'(RC) + 1) begin bad++; $display("FAIL read_stall: got %0d want %0d", o.stalls, RC + 1); end
    total++; if (o.rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL read_data: got %h want deadbeef", o.rd); end
    total++; if (o.we_lo != 0) begin bad++; $display("FAIL read_we: got %0d want 0", o.we_lo); end
  endtask

  task automatic test_write();
    obs_t o;
    run_txn(1'b0, 1'b1, 32'h003F_FFFC, 32'h1234_5678, 4'b0101, 1'b0, o);
    ref_mem[10'h3FF] = merge(ref_mem[10'h3FF], 32'h1234_5678, 4'b0101);
    total++; if (o.addr !== 20'hFFFFF) begin bad++; $display("FAIL write_addr: got %h want fffff", o.addr); end
    total++; if (o.be !== 4'b1010) begin bad++; $display("FAIL write_be_n: got %b want 1010", o.be); end
    total++; if (o.we_lo != int'(WC)) begin bad++; $display("FAIL write_we_cycles: got %0d want %0d", o.we_lo, WC); end
    total++; if (o.doe != int'(WC) + 2) begin bad++; $display("FAIL write_oe_cycles: got %0d want %0d", o.doe, WC + 2); end
    total++; if (o.stalls != int'(WC) + 3) begin bad++; $display("FAIL write_stall: got %0d want %0d", o.stalls, WC + 3); end
    total++; if (o.wdata !== 32'h1234_5678) begin bad++; $display("FAIL write_data: got %h want 12345678", o.wdata); end
    run_txn(1'b1, 1'b0, 32'h003F_FFFC, 32'h0, 4'h0, 1'b0, o);
    exp_rd = ref_mem[10'h3FF];
    total++; if (o.rd !== 32'h0034_0078) begin bad++; $display("FAIL write_readback: got %h want 00340078", o.rd); end
  endtask

  task automatic test_mask_zero();
    obs_t o;
    run_txn(1'b0, 1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 4'h0, 1'b0, o);
    total++; if (o.ce_lo != 0) begin bad++; $display("FAIL mask0_ce: got %0d want 0", o.ce_lo); end
    total++; if (o.we_lo != 0) begin bad++; $display("FAIL mask0_we: got %0d want 0", o.we_lo); end
    total++; if (o.stalls != 1) begin bad++; $display("FAIL mask0_stall: got %0d want 1", o.stalls); end
  endtask

  task automatic test_read_and_write();
    obs_t o;
    run_txn(1'b1, 1'b1, 32'h0000_0030, 32'hA5A5_0F0F, 4'hF, 1'b0, o);
    ref_mem[12] = merge(ref_mem[12], 32'hA5A5_0F0F, 4'hF);
    total++; if (o.we_lo != int'(WC)) begin bad++; $display("FAIL both_we_cycles: got %0d want %0d", o.we_lo, WC); end
    total++; if (o.stalls != int'(WC) + 3) begin bad++; $display("FAIL both_stall: got %0d want %0d", o.stalls, WC + 3); end
    total++; if (o.rd !== exp_rd) begin bad++; $display("FAIL both_rd_held: got %h want %h", o.rd, exp_rd); end
  endtask

  task automatic test_withdraw();
    obs_t o;
    @(negedge clk);
    bus_write = 1'b1; bus_address = 32'h0000_0040; bus_data_wr = 32'hCAFE_F00D; bus_mask = 4'hF;
    @(negedge clk);
    bus_write = 1'b0;
    #1;
    total++; if (bus_stall !== 1'b0) begin bad++; $display("FAIL withdraw_stall: got %b want 0", bus_stall); end
    repeat (8) @(negedge clk);
    ref_mem[16] = merge(ref_mem[16], 32'hCAFE_F00D, 4'hF);
    run_txn(1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'h0, 1'b0, o);
    exp_rd = ref_mem[16];
    total++; if (o.rd !== exp_rd) begin bad++; $display("FAIL withdraw_data: got %h want %h", o.rd, exp_rd); end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    run_txn(1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 1'b0, o);
    exp_rd = ref_mem[4];
    run_txn(1'b0, 1'b1, 32'h0000_0014, 32'h0BAD_CAFE, 4'hF, 1'b0, o);
    ref_mem[5] = merge(ref_mem[5], 32'h0BAD_CAFE, 4'hF);
    total++; if (last_gap != 2) begin bad++; $display("FAIL b2b_gap: got %0d want 2", last_gap); end
  endtask

  task automatic test_reset_mid_write();
    obs_t o;
    bit found;
    found = 1'b0;
    @(negedge clk);
    bus_write = 1'b1; bus_address = 32'h0000_0800; bus_data_wr = 32'h7777_7777; bus_mask = 4'hF;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!sram_we_n) begin found = 1'b1; break; end
    end
    total++; if (!found) begin bad++; $display("FAIL rstmid_pulse: we_n never low, required low"); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (sram_we_n !== 1'b1) begin bad++; $display("FAIL rstmid_we_n: got %b want 1", sram_we_n); end
    total++; if (sram_ce_n !== 1'b1) begin bad++; $display("FAIL rstmid_ce_n: got %b want 1", sram_ce_n); end
    total++; if (sram_data_oe !== 1'b0) begin bad++; $display("FAIL rstmid_data_oe: got %b want 0", sram_data_oe); end
    bus_write = 1'b0;
    exp_rd = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(1'b1, 1'b0, 32'h0000_0014, 32'h0, 4'h0, 1'b0, o);
    exp_rd = ref_mem[5];
    total++; if (o.stalls != int'(RC) + 1) begin bad++; $display("FAIL rstmid_read_stall: got %0d want %0d", o.stalls, RC + 1); end
    total++; if (o.rd !== exp_rd) begin bad++; $display("FAIL rstmid_read_data: got %h want %h", o.rd, exp_rd); end
  endtask

  task automatic test_random();
    obs_t o;
    int unsigned idx;
    int unsigned op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
    logic        rd;
    logic        wr;
    bit          scr;
    for (int n = 0; n < 60; n++) begin
      idx  = $urandom_range(0, 63);
      op   = $urandom_range(0, 2);
      addr = ($urandom & 32'hFFC0_0003) | (idx << 2);
      data = $urandom;
      mask = 4'($urandom);
      scr  = 1'($urandom_range(0, 1));
      rd   = (op != 1);
      wr   = (op != 0);
      run_txn(rd, wr, addr, data, mask, scr, o);
      if (wr) begin
        if (mask == 4'h0) begin
          total++; if (o.stalls != 1) begin bad++; $display("FAIL rnd_mask0_stall n=%0d: got %0d want 1", n, o.stalls); end
          total++; if (o.ce_lo != 0) begin bad++; $display("FAIL rnd_mask0_ce n=%0d: got %0d want 0", n, o.ce_lo); end
        end else begin
          total++; if (o.stalls != int'(WC) + 3) begin bad++; $display("FAIL rnd_wr_stall n=%0d: got %0d want %0d", n, o.stalls, WC + 3); end
          total++; if (o.addr !== 20'(idx)) begin bad++; $display("FAIL rnd_wr_addr n=%0d: got %h want %h", n, o.addr, idx); end
          total++; if (o.be !== ~mask) begin bad++; $display("FAIL rnd_wr_be n=%0d: got %b want %b", n, o.be, ~mask); end
          total++; if (o.wdata !== data) begin bad++; $display("FAIL rnd_wr_data n=%0d: got %h want %h", n, o.wdata, data); end
          total++; if (o.we_lo != int'(WC)) begin bad++; $display("FAIL rnd_wr_we n=%0d: got %0d want %0d", n, o.we_lo, WC); end
          ref_mem[idx] = merge(ref_mem[idx], data, mask);
        end
        total++; if (o.rd !== exp_rd) begin bad++; $display("FAIL rnd_wr_rdhold n=%0d: got %h want %h", n, o.rd, exp_rd); end
      end else begin
        exp_rd = ref_mem[idx];
        total++; if (o.stalls != int'(RC) + 1) begin bad++; $display("FAIL rnd_rd_stall n=%0d: got %0d want %0d", n, o.stalls, RC + 1); end
        total++; if (o.oe_lo != int'(RC)) begin bad++; $display("FAIL rnd_rd_oe n=%0d: got %0d want %0d", n, o.oe_lo, RC); end
        total++; if (o.rd !== exp_rd) begin bad++; $display("FAIL rnd_rd_data n=%0d: got %h want %h", n, o.rd, exp_rd); end
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_read();
    test_write();
    test_mask_zero();
    test_read_and_write();
    test_withdraw();
    test_back_to_back();
    test_reset_mid_write();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
